// File: rtl/fruit_launcher.sv
// Single-fruit trajectory engine: spawn at the bottom edge, parabolic flight per frame, slice/miss detect.
// Launch source: FRUIT_LFSR_EN selects the 16-bit LFSR; otherwise a fixed 4-entry launch table.
module fruit_launcher #(
  parameter int SIZE         = 16,
  parameter int GRAVITY      = 1,
  parameter int SPAWN_DELAY  = 30,
  parameter int SPLAT_FRAMES = 8,
  parameter int Y_BOTTOM     = 479
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       slice,
  output logic [9:0] FruitX,
  output logic [9:0] FruitY,
  output logic [9:0] FruitS,
  output logic       fruit_active,
  output logic       sliced_pulse,
  output logic       missed_pulse
);
  // state    | meaning
  // S_WAIT   | no fruit; counting frame ticks down to the next launch
  // S_FLIGHT | fruit moving; slice or bottom crossing ends the flight
  // S_SPLAT  | sliced fruit frozen on screen for SPLAT_FRAMES ticks
  typedef enum logic [1:0] {S_WAIT, S_FLIGHT, S_SPLAT} state_t;

  localparam logic signed [10:0] X_MIN  = 11'(SIZE);
  localparam logic signed [10:0] X_MAX  = 11'(639 - SIZE);
  localparam logic signed [10:0] Y_MAX  = 11'(Y_BOTTOM);
  localparam logic signed [8:0]  GRAV9  = 9'(GRAVITY);
  localparam logic signed [8:0]  VY_SAT = 9'sd31;

  state_t r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [9:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic signed [7:0] r_vx, r_vy, w_vx_nxt, w_vy_nxt;
  logic r_active, r_sliced, r_missed;
  logic w_active_nxt, w_sliced_nxt, w_missed_nxt;

  logic w_launch;
  logic [9:0] w_launch_x;
  logic signed [7:0] w_launch_vx, w_launch_vy;
  logic signed [10:0] w_nx, w_ny;
  logic signed [8:0] w_vy_sum;

  assign w_launch = (r_state == S_WAIT) && frame_tick && (r_cnt == '0);

`ifdef FRUIT_LFSR_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge Clk) begin
    if (Reset) r_lfsr <= 16'hACE1;
    else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  always_comb begin
    w_launch_x  = 10'd64 + {1'b0, r_lfsr[8:0]};
    w_launch_vx = $signed({5'b0, r_lfsr[11:9]}) - 8'sd4;
    w_launch_vy = -(8'sd16 + $signed({5'b0, r_lfsr[13:12], 1'b0}));
  end
`else
  logic [1:0] r_idx;
  always_ff @(posedge Clk) begin
    if (Reset)         r_idx <= 2'd0;
    else if (w_launch) r_idx <= r_idx + 2'd1;
  end

  always_comb begin
    w_launch_x  = 10'd320;
    w_launch_vx = 8'sd2;
    w_launch_vy = -8'sd16;
    case (r_idx)
      2'd1: begin w_launch_x = 10'd100; w_launch_vx = -8'sd3; w_launch_vy = -8'sd18; end
      2'd2: begin w_launch_x = 10'd540; w_launch_vx = 8'sd3;  w_launch_vy = -8'sd20; end
      2'd3: begin w_launch_x = 10'd200; w_launch_vx = 8'sd1;  w_launch_vy = -8'sd22; end
      default: ;
    endcase
  end
`endif

  assign w_nx     = $signed({1'b0, r_x}) + $signed({{3{r_vx[7]}}, r_vx});
  assign w_ny     = $signed({1'b0, r_y}) + $signed({{3{r_vy[7]}}, r_vy});
  assign w_vy_sum = $signed({r_vy[7], r_vy}) + GRAV9;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_vx_nxt     = r_vx;
    w_vy_nxt     = r_vy;
    w_active_nxt = r_active;
    w_sliced_nxt = 1'b0;
    w_missed_nxt = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (w_launch) begin
          w_state_nxt  = S_FLIGHT;
          w_x_nxt      = w_launch_x;
          w_y_nxt      = 10'(Y_BOTTOM);
          w_vx_nxt     = w_launch_vx;
          w_vy_nxt     = w_launch_vy;
          w_active_nxt = 1'b1;
        end else if (frame_tick) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_FLIGHT: begin
        // a slice in the same cycle as a tick pre-empts both the move and any miss
        if (slice) begin
          w_state_nxt  = S_SPLAT;
          w_cnt_nxt    = 8'(SPLAT_FRAMES);
          w_active_nxt = 1'b0;
          w_sliced_nxt = 1'b1;
        end else if (frame_tick) begin
          if (w_nx < X_MIN || w_nx > X_MAX) w_vx_nxt = -r_vx;
          else                              w_x_nxt  = w_nx[9:0];
          w_vy_nxt = (w_vy_sum > VY_SAT) ? 8'sd31 : w_vy_sum[7:0];
          if (w_ny > Y_MAX) begin
            w_state_nxt  = S_WAIT;
            w_cnt_nxt    = 8'(SPAWN_DELAY);
            w_active_nxt = 1'b0;
            w_missed_nxt = 1'b1;
          end else begin
            w_y_nxt = w_ny[9:0];
          end
        end
      end
      S_SPLAT: begin
        // leave on the tick that brings the count to zero: SPLAT_FRAMES ticks frozen
        if (frame_tick) begin
          if (r_cnt <= 8'd1) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = 8'(SPAWN_DELAY);
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= S_WAIT;
      r_cnt    <= 8'(SPAWN_DELAY);
      r_x      <= 10'd320;
      r_y      <= 10'(Y_BOTTOM);
      r_vx     <= 8'sd0;
      r_vy     <= 8'sd0;
      r_active <= 1'b0;
      r_sliced <= 1'b0;
      r_missed <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_vx     <= w_vx_nxt;
      r_vy     <= w_vy_nxt;
      r_active <= w_active_nxt;
      r_sliced <= w_sliced_nxt;
      r_missed <= w_missed_nxt;
    end
  end

  assign FruitX       = r_x;
  assign FruitY       = r_y;
  assign FruitS       = 10'(SIZE);
  assign fruit_active = r_active;
  assign sliced_pulse = r_sliced;
  assign missed_pulse = r_missed;
endmodule

// File: tb/tb_fruit_launcher.sv
// Scoreboard bench for fruit_launcher (default launch-table build).
// Expectations are queued before each stimulus cycle and compared after the sampling edge.
module tb_fruit_launcher;
  logic       Clk = 1'b0;
  logic       Reset, frame_tick, slice;
  logic [9:0] FruitX, FruitY, FruitS;
  logic       fruit_active, sliced_pulse, missed_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string tag;
    int    sel;
    int    exp_v;
  } exp_t;
  exp_t sb_q[$];

  localparam int SEL_X = 0, SEL_Y = 1, SEL_ACT = 2, SEL_SLC = 3, SEL_MIS = 4, SEL_S = 5;

  fruit_launcher dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .slice(slice),
    .FruitX(FruitX), .FruitY(FruitY), .FruitS(FruitS),
    .fruit_active(fruit_active), .sliced_pulse(sliced_pulse), .missed_pulse(missed_pulse)
  );

  always #10 Clk = ~Clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int dut_out(input int sel);
    case (sel)
      SEL_X:   return int'(FruitX);
      SEL_Y:   return int'(FruitY);
      SEL_ACT: return int'(fruit_active);
      SEL_SLC: return int'(sliced_pulse);
      SEL_MIS: return int'(missed_pulse);
      default: return int'(FruitS);
    endcase
  endfunction

  task automatic want(input string tag, input int sel, input int exp_v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp_v = exp_v;
    sb_q.push_back(e);
  endtask

  task automatic step(input bit t, input bit s, input bit r);
    exp_t e;
    @(negedge Clk);
    frame_tick = t; slice = s; Reset = r;
    @(posedge Clk);
    #1;
    frame_tick = 1'b0; slice = 1'b0; Reset = 1'b0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, dut_out(e.sel), e.exp_v);
    end
  endtask

  // one frame: tick cycle, then an idle cycle that confirms pulses last one cycle
  task automatic tick(input bit s);
    step(1'b1, s, 1'b0);
    want("sliced_one_cycle", SEL_SLC, 0);
    want("missed_one_cycle", SEL_MIS, 0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  // 8 splat ticks (position frozen) + 30 wait ticks + launch tick
  task automatic splat_then_launch(input int fx, input int fy, input int lx);
    for (int i = 1; i <= 38; i++) begin
      want("splat_wait_act", SEL_ACT, 0);
      want("ignored_slice", SEL_SLC, 0);
      if (i <= 8) begin
        want("splat_frozen_x", SEL_X, fx);
        want("splat_frozen_y", SEL_Y, fy);
      end
      tick(i == 3 || i == 20);
    end
    want("relaunch_act", SEL_ACT, 1);
    want("relaunch_x", SEL_X, lx);
    want("relaunch_y", SEL_Y, 479);
    tick(1'b0);
  endtask

  task automatic wait_then_launch(input int lx);
    for (int i = 1; i <= 30; i++) begin
      want("wait_act", SEL_ACT, 0);
      tick(1'b0);
    end
    want("launch_act", SEL_ACT, 1);
    want("launch_x", SEL_X, lx);
    want("launch_y", SEL_Y, 479);
    tick(1'b0);
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; slice = 1'b0;
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    want("rst_x", SEL_X, 320);
    want("rst_y", SEL_Y, 479);
    want("rst_s", SEL_S, 16);
    want("rst_act", SEL_ACT, 0);
    want("rst_sliced", SEL_SLC, 0);
    want("rst_missed", SEL_MIS, 0);
    step(1'b1, 1'b0, 1'b1);

    // 30 ticks of spawn delay; slice in WAIT must be ignored
    for (int i = 1; i <= 30; i++) begin
      want("spawn_act", SEL_ACT, 0);
      want("spawn_x", SEL_X, 320);
      want("spawn_y", SEL_Y, 479);
      want("wait_slice_ignored", SEL_SLC, 0);
      tick(i % 3 == 0);
    end
    want("launch0_act", SEL_ACT, 1);
    want("launch0_x", SEL_X, 320);
    want("launch0_y", SEL_Y, 479);
    tick(1'b0);

    // entry 0 flight: x=320+2n, y=479-16n+n(n-1)/2
    for (int n = 1; n <= 33; n++) begin
      want("flight0_x", SEL_X, 320 + 2 * n);
      want("flight0_y", SEL_Y, 479 - 16 * n + n * (n - 1) / 2);
      want("flight0_act", SEL_ACT, 1);
      want("flight0_missed", SEL_MIS, 0);
      tick(1'b0);
    end
    want("miss_pulse", SEL_MIS, 1);
    want("miss_act", SEL_ACT, 0);
    want("miss_sliced", SEL_SLC, 0);
    tick(1'b0);

    // entry 1, reset at its 10th tick
    wait_then_launch(100);
    for (int n = 1; n <= 9; n++) begin
      want("flight1_x", SEL_X, 100 - 3 * n);
      want("flight1_y", SEL_Y, 479 - 18 * n + n * (n - 1) / 2);
      tick(1'b0);
    end
    want("midrst_x", SEL_X, 320);
    want("midrst_y", SEL_Y, 479);
    want("midrst_act", SEL_ACT, 0);
    want("midrst_sliced", SEL_SLC, 0);
    want("midrst_missed", SEL_MIS, 0);
    step(1'b1, 1'b0, 1'b1);

    // launch index back to entry 0; slice 5 ticks in
    wait_then_launch(320);
    for (int n = 1; n <= 5; n++) begin
      want("flight0b_x", SEL_X, 320 + 2 * n);
      want("flight0b_y", SEL_Y, 479 - 16 * n + n * (n - 1) / 2);
      tick(1'b0);
    end
    want("slice_pulse", SEL_SLC, 1);
    want("slice_act", SEL_ACT, 0);
    want("slice_x", SEL_X, 330);
    want("slice_y", SEL_Y, 409);
    step(1'b0, 1'b1, 1'b0);
    want("slice_one_cycle", SEL_SLC, 0);
    step(1'b0, 1'b0, 1'b0);
    splat_then_launch(330, 409, 100);

    // entry 1: slice on the same cycle as its first tick, no move
    want("slicetick_pulse", SEL_SLC, 1);
    want("slicetick_missed", SEL_MIS, 0);
    want("slicetick_act", SEL_ACT, 0);
    want("slicetick_x", SEL_X, 100);
    want("slicetick_y", SEL_Y, 479);
    tick(1'b1);
    splat_then_launch(100, 479, 540);

    // entry 2: right-wall bounce at tick 28
    for (int n = 1; n <= 41; n++) begin
      want("bounce_x", SEL_X, (n <= 27) ? 540 + 3 * n : 621 - 3 * (n - 28));
      want("bounce_y", SEL_Y, 479 - 20 * n + n * (n - 1) / 2);
      want("bounce_act", SEL_ACT, 1);
      tick(1'b0);
    end
    // tick 42 would miss; slice wins
    want("slicemiss_sliced", SEL_SLC, 1);
    want("slicemiss_missed", SEL_MIS, 0);
    want("slicemiss_act", SEL_ACT, 0);
    want("slicemiss_x", SEL_X, 582);
    want("slicemiss_y", SEL_Y, 479);
    tick(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
